// File: rtl/oscilo_aux_units_if.sv
// oscilo_aux_units_if: dispatcher-side bundle for the oscilloscope auxiliary units.
// Signals:
//   adc_clk/adc_data                       sampler strobe in, synthetic ADC sample out
//   mc_activate/mc_done                    memory-filler enable in, finished out
//   mc_mem_clk/addr/data/we                sample-memory write port out
//   rp_activate/rp_done                    echo-unit enable in, finished out
//   rx_ready/rx_data                       received UART byte in
//   tx_active/tx_done                      UART transmitter status in
//   rp_tx_data/rp_tx_start                 byte and start request to the transmitter out
// Modports: master = dispatcher/sampler side, slave = oscilo_aux_units.
interface oscilo_aux_units_if;
    logic       adc_clk;
    logic [7:0] adc_data;
    logic       mc_activate;
    logic       mc_done;
    logic       mc_mem_clk;
    logic [7:0] mc_mem_addr;
    logic [7:0] mc_mem_data;
    logic       mc_mem_we;
    logic       rp_activate;
    logic       rp_done;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_active;
    logic       tx_done;
    logic [7:0] rp_tx_data;
    logic       rp_tx_start;

    modport master (
        output adc_clk, mc_activate, rp_activate, rx_ready, rx_data, tx_active, tx_done,
        input  adc_data, mc_done, mc_mem_clk, mc_mem_addr, mc_mem_data, mc_mem_we,
               rp_done, rp_tx_data, rp_tx_start
    );

    modport slave (
        input  adc_clk, mc_activate, rp_activate, rx_ready, rx_data, tx_active, tx_done,
        output adc_data, mc_done, mc_mem_clk, mc_mem_addr, mc_mem_data, mc_mem_we,
               rp_done, rp_tx_data, rp_tx_start
    );
endinterface

// File: rtl/oscilo_aux_units.sv
// oscilo_aux_units: synthetic ADC counter, 256-entry sample-memory filler and one-byte UART echo.
// Ports:
//   i_clk    system clock, all logic on its rising edge
//   i_reset  synchronous active-low reset
//   if_bus   oscilo_aux_units_if.slave (ADC, memory-filler, echo and UART signals)
module oscilo_aux_units (
    input  logic                  i_clk,
    input  logic                  i_reset,
    oscilo_aux_units_if.slave     if_bus
);
    typedef enum logic [2:0] {MC_IDLE, MC_WAIT_FILL, MC_WRITE_LO, MC_WRITE_HI, MC_DONE} mc_state_t;
    typedef enum logic [2:0] {RP_IDLE, RP_WAIT_RX, RP_SEND, RP_WAIT_TX, RP_DONE} rp_state_t;

    logic       r_adc_prev;
    logic [7:0] r_adc_data;

    mc_state_t  r_mc_state;
    logic [7:0] r_mc_addr;
    logic [7:0] r_mc_fill;
    logic [7:0] r_mc_addr_o;
    logic [7:0] r_mc_data_o;
    logic       r_mc_we;
    logic       r_mc_clk;
    logic       r_mc_done;

    rp_state_t  r_rp_state;
    logic [7:0] r_rp_tx_data;
    logic       r_rp_tx_start;
    logic       r_rp_done;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_adc_prev <= 1'b0;
            r_adc_data <= 8'd0;
        end else begin
            r_adc_prev <= if_bus.adc_clk;
            if (if_bus.adc_clk && !r_adc_prev)
                r_adc_data <= r_adc_data + 8'd1;
        end
    end

    // Memory-port outputs are a registered decode of the current state, so address and
    // data are stable for a full cycle before each mem_clk rising edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_mc_state  <= MC_IDLE;
            r_mc_addr   <= 8'd0;
            r_mc_fill   <= 8'd0;
            r_mc_addr_o <= 8'd0;
            r_mc_data_o <= 8'd0;
            r_mc_we     <= 1'b0;
            r_mc_clk    <= 1'b0;
            r_mc_done   <= 1'b0;
        end else if (!if_bus.mc_activate) begin
            r_mc_state <= MC_IDLE;
            r_mc_we    <= 1'b0;
            r_mc_clk   <= 1'b0;
            r_mc_done  <= 1'b0;
        end else begin
            r_mc_we   <= (r_mc_state == MC_WRITE_LO) || (r_mc_state == MC_WRITE_HI);
            r_mc_clk  <= r_mc_state == MC_WRITE_HI;
            r_mc_done <= r_mc_state == MC_DONE;
            if (r_mc_state == MC_WRITE_LO) begin
                r_mc_addr_o <= r_mc_addr;
                r_mc_data_o <= r_mc_fill;
            end
            case (r_mc_state)
                MC_IDLE:      r_mc_state <= MC_WAIT_FILL;
                MC_WAIT_FILL: if (if_bus.rx_ready) begin
                    r_mc_fill  <= if_bus.rx_data;
                    r_mc_addr  <= 8'd0;
                    r_mc_state <= MC_WRITE_LO;
                end
                MC_WRITE_LO:  r_mc_state <= MC_WRITE_HI;
                MC_WRITE_HI:  if (r_mc_addr == 8'hFF) begin
                    r_mc_state <= MC_DONE;
                end else begin
                    r_mc_addr  <= r_mc_addr + 8'd1;
                    r_mc_state <= MC_WRITE_LO;
                end
                MC_DONE:      r_mc_state <= MC_DONE;
                default:      r_mc_state <= MC_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rp_state    <= RP_IDLE;
            r_rp_tx_data  <= 8'd0;
            r_rp_tx_start <= 1'b0;
            r_rp_done     <= 1'b0;
        end else if (!if_bus.rp_activate) begin
            r_rp_state    <= RP_IDLE;
            r_rp_tx_start <= 1'b0;
            r_rp_done     <= 1'b0;
        end else begin
            r_rp_tx_start <= 1'b0;
            case (r_rp_state)
                RP_IDLE:    r_rp_state <= RP_WAIT_RX;
                RP_WAIT_RX: if (if_bus.rx_ready) begin
                    r_rp_tx_data <= if_bus.rx_data;
                    r_rp_state   <= RP_SEND;
                end
                RP_SEND:    if (!if_bus.tx_active) begin
                    r_rp_tx_start <= 1'b1;
                    r_rp_state    <= RP_WAIT_TX;
                end
                RP_WAIT_TX: if (if_bus.tx_done) begin
                    r_rp_done  <= 1'b1;
                    r_rp_state <= RP_DONE;
                end
                RP_DONE:    r_rp_state <= RP_DONE;
                default:    r_rp_state <= RP_IDLE;
            endcase
        end
    end

    assign if_bus.adc_data    = r_adc_data;
    assign if_bus.mc_done     = r_mc_done;
    assign if_bus.mc_mem_clk  = r_mc_clk;
    assign if_bus.mc_mem_addr = r_mc_addr_o;
    assign if_bus.mc_mem_data = r_mc_data_o;
    assign if_bus.mc_mem_we   = r_mc_we;
    assign if_bus.rp_done     = r_rp_done;
    assign if_bus.rp_tx_data  = r_rp_tx_data;
    assign if_bus.rp_tx_start = r_rp_tx_start;
endmodule

// File: tb/tb_oscilo_aux_units.sv
// tb_oscilo_aux_units: self-checking bench for oscilo_aux_units with a cycle-level behavioural model.
module tb_oscilo_aux_units;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    oscilo_aux_units_if bus ();

    oscilo_aux_units dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .if_bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: the filler is described by the cycle count since the fill byte was
    // captured; the echo unit by three progress flags.
    logic [7:0] m_adc = 0;
    logic       m_adc_prev = 0;
    bit         m_mc_on = 0;
    int         m_n = -1;
    logic [7:0] m_fill = 0;
    logic [7:0] e_addr = 0, e_data = 0;
    logic       e_we = 0, e_mclk = 0, e_mdone = 0;
    bit         m_rp_on = 0, e_got = 0, e_sent = 0, e_fin = 0;
    logic [7:0] e_txd = 0;
    logic       e_start = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_adc = 0; m_adc_prev = 0;
            m_mc_on = 0; m_n = -1; m_fill = 0;
            e_addr = 0; e_data = 0; e_we = 0; e_mclk = 0; e_mdone = 0;
            m_rp_on = 0; e_got = 0; e_sent = 0; e_fin = 0; e_txd = 0; e_start = 0;
        end else begin
            if (bus.adc_clk && !m_adc_prev) m_adc = m_adc + 8'd1;
            m_adc_prev = bus.adc_clk;
            if (!bus.mc_activate) begin
                m_mc_on = 0; m_n = -1;
                e_we = 0; e_mclk = 0; e_mdone = 0;
            end else begin
                if (!m_mc_on) m_mc_on = 1;
                else if (m_n < 0) begin
                    if (bus.rx_ready) begin m_fill = bus.rx_data; m_n = 0; end
                end else if (m_n < 1000) m_n++;
                e_we    = m_n >= 1 && m_n <= 512;
                e_mclk  = m_n >= 2 && m_n <= 512 && m_n % 2 == 0;
                e_mdone = m_n >= 513;
                if (m_n >= 1 && m_n <= 512 && m_n % 2 == 1) begin
                    e_addr = 8'((m_n - 1) / 2);
                    e_data = m_fill;
                end
            end
            e_start = 0;
            if (!bus.rp_activate) begin
                m_rp_on = 0; e_got = 0; e_sent = 0; e_fin = 0;
            end else if (!m_rp_on) m_rp_on = 1;
            else if (!e_got) begin
                if (bus.rx_ready) begin e_got = 1; e_txd = bus.rx_data; end
            end else if (!e_sent) begin
                if (!bus.tx_active) begin e_sent = 1; e_start = 1; end
            end else if (!e_fin && bus.tx_done) e_fin = 1;
        end
    end

    always @(negedge clk) begin
        chk("adc_data", bus.adc_data, m_adc);
        chk("mc_done", {7'd0, bus.mc_done}, {7'd0, e_mdone});
        chk("mc_mem_clk", {7'd0, bus.mc_mem_clk}, {7'd0, e_mclk});
        chk("mc_mem_we", {7'd0, bus.mc_mem_we}, {7'd0, e_we});
        chk("mc_mem_addr", bus.mc_mem_addr, e_addr);
        chk("mc_mem_data", bus.mc_mem_data, e_data);
        chk("rp_done", {7'd0, bus.rp_done}, {7'd0, e_fin});
        chk("rp_tx_data", bus.rp_tx_data, e_txd);
        chk("rp_tx_start", {7'd0, bus.rp_tx_start}, {7'd0, e_start});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        bus.rx_ready = 1; bus.rx_data = d;
        step(1);
        bus.rx_ready = 0;
    endtask

    int k, rises;

    initial begin
        bus.adc_clk = 0; bus.mc_activate = 0; bus.rp_activate = 0;
        bus.rx_ready = 0; bus.rx_data = 0; bus.tx_active = 0; bus.tx_done = 0;
        step(3);
        chk("reset_adc", bus.adc_data, 8'h00);
        chk("reset_tx_data", bus.rp_tx_data, 8'h00);
        rst_n = 1;
        step(2);
        for (int i = 0; i < 257; i++) begin
            bus.adc_clk = 1; step(1);
            bus.adc_clk = 0; step(1);
            if (i == 255) chk("adc_wrap", bus.adc_data, 8'h00);
        end
        chk("adc_257", bus.adc_data, 8'h01);
        bus.adc_clk = 1; step(5);
        bus.adc_clk = 0; step(1);
        chk("adc_long_high", bus.adc_data, 8'h02);

        bus.mc_activate = 1;
        step(3);
        rx_pulse(8'hA5);
        k = 0; rises = 0;
        while (!bus.mc_done && k < 600) begin
            step(1); k++;
            if (bus.mc_mem_clk) rises++;
        end
        chk("fill_done_latency_lo", 8'(k), 8'(513));
        chk("fill_done_latency_hi", 8'(k >> 8), 8'(513 >> 8));
        chk("fill_clk_highs", 8'(rises - 1), 8'd255);
        chk("fill_data", bus.mc_mem_data, 8'hA5);
        chk("fill_last_addr", bus.mc_mem_addr, 8'hFF);
        bus.mc_activate = 0;
        step(1);
        chk("fill_done_fall", {7'd0, bus.mc_done}, 8'd0);

        bus.mc_activate = 1;
        step(2);
        rx_pulse(8'($urandom));
        k = 0;
        while (!(bus.mc_mem_addr == 8'd100 && bus.mc_mem_we) && k < 400) begin step(1); k++; end
        chk("abort_reached_100", {7'd0, k < 400}, 8'd1);
        bus.mc_activate = 0;
        step(1);
        chk("abort_we", {7'd0, bus.mc_mem_we}, 8'd0);
        chk("abort_clk", {7'd0, bus.mc_mem_clk}, 8'd0);
        bus.mc_activate = 1;
        step(6);
        chk("abort_waits", {7'd0, bus.mc_mem_we}, 8'd0);
        rx_pulse(8'h5C);
        step(1);
        chk("restart_addr0", bus.mc_mem_addr, 8'h00);
        chk("restart_data", bus.mc_mem_data, 8'h5C);
        k = 0;
        while (!bus.mc_done && k < 600) begin step(1); k++; end
        bus.mc_activate = 0;
        step(2);

        bus.rp_activate = 1;
        step(2);
        rx_pulse(8'h3C);
        chk("echo_data", bus.rp_tx_data, 8'h3C);
        chk("echo_start_before", {7'd0, bus.rp_tx_start}, 8'd0);
        step(1);
        chk("echo_start", {7'd0, bus.rp_tx_start}, 8'd1);
        step(1);
        chk("echo_start_once", {7'd0, bus.rp_tx_start}, 8'd0);
        step(18);
        bus.tx_done = 1; step(1); bus.tx_done = 0;
        chk("echo_done", {7'd0, bus.rp_done}, 8'd1);
        bus.rp_activate = 0;
        step(1);
        chk("echo_done_fall", {7'd0, bus.rp_done}, 8'd0);

        bus.rp_activate = 1;
        step(2);
        bus.tx_active = 1;
        rx_pulse(8'hC3);
        rises = 0;
        repeat (10) begin step(1); if (bus.rp_tx_start) rises++; end
        chk("busy_no_start", 8'(rises), 8'd0);
        bus.tx_active = 0;
        step(1);
        chk("busy_start", {7'd0, bus.rp_tx_start}, 8'd1);
        step(3);
        bus.tx_done = 1; step(1); bus.tx_done = 0;
        bus.rp_activate = 0;
        step(2);

        bus.mc_activate = 1;
        step(2);
        rx_pulse(8'h5A);
        step(2);
        bus.rp_activate = 1;
        step(2);
        rx_pulse(8'h77);
        step(3);
        k = 0;
        while (!(bus.mc_mem_we && !bus.mc_mem_clk) && k < 10) begin step(1); k++; end
        rst_n = 0; bus.mc_activate = 0; bus.rp_activate = 0;
        step(1);
        rst_n = 1;
        chk("rst_adc", bus.adc_data, 8'h00);
        chk("rst_we", {7'd0, bus.mc_mem_we}, 8'd0);
        chk("rst_addr", bus.mc_mem_addr, 8'h00);
        chk("rst_txd", bus.rp_tx_data, 8'h00);
        step(2);
        rx_pulse(8'h99);
        step(3);
        chk("rst_idle_txd", bus.rp_tx_data, 8'h00);

        for (int c = 0; c < 4000; c++) begin
            bus.adc_clk   = 1'($urandom);
            bus.rx_ready  = $urandom_range(0, 7) == 0;
            bus.rx_data   = 8'($urandom);
            bus.tx_active = 1'($urandom);
            bus.tx_done   = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 699) == 0) bus.mc_activate = !bus.mc_activate;
            if ($urandom_range(0, 24) == 0) bus.rp_activate = !bus.rp_activate;
            rst_n = $urandom_range(0, 999) != 0;
            step(1);
        end
        rst_n = 1; bus.rx_ready = 0; bus.tx_done = 0;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
